// File: rtl/hazard_response_ctrl_if.sv
// Request/control bundle between the decode/execute/memory stages and the pipeline sequencer.
// The pipeline side (master) raises hazard requests; the sequencer (slave) returns stage controls.
interface hazard_response_ctrl_if;
  logic load_use_stall;
  logic branch_taken_ex;
  logic ret_decode;
  logic pc_load_valid;
  logic int_req;

  logic pc_write_en;
  logic ifid_write_en;
  logic ifid_flush;
  logic idex_bubble;
  logic int_ack;

  modport master (
    output load_use_stall, branch_taken_ex, ret_decode, pc_load_valid, int_req,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, int_ack
  );

  modport slave (
    input  load_use_stall, branch_taken_ex, ret_decode, pc_load_valid, int_req,
    output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, int_ack
  );
endinterface

// File: rtl/hazard_response_ctrl.sv
// Pipeline hazard sequencer: same-cycle stage controls from state and requests, multi-cycle
// RET/RTI and interrupt-entry sequences, saturating stall counter and sticky RET-timeout flag.
module hazard_response_ctrl #(
  parameter int RET_TIMEOUT = 4,
  parameter int INT_LATENCY = 2,
  parameter int CNT_W       = 3,
  parameter int STAT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_response_ctrl_if.slave hz,
  input  logic                  clr_stats,
  output logic                  hazard_err,
  output logic [1:0]            state_dbg,
  output logic [STAT_W-1:0]     stall_cycles
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_RET_WAIT  = 2'd1;
  localparam logic [1:0] ST_INT_ENTRY = 2'd2;

  localparam logic [CNT_W-1:0] RET_INIT = CNT_W'(RET_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] INT_INIT = CNT_W'(INT_LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  logic pc_we, ifid_we, flush, bubble, ack;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    flush   = 1'b0;
    bubble  = 1'b0;
    ack     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (hz.branch_taken_ex) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (hz.load_use_stall) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          bubble  = 1'b1;
        end else if (hz.ret_decode) begin
          // RET itself moves on into ID/EX; only the younger fetch is squashed.
          pc_we   = 1'b0;
          flush   = 1'b1;
          state_d = ST_RET_WAIT;
          cnt_d   = RET_INIT;
        end else if (hz.int_req) begin
          pc_we   = 1'b0;
          flush   = 1'b1;
          bubble  = 1'b1;
          state_d = ST_INT_ENTRY;
          cnt_d   = INT_INIT;
        end
      end

      ST_RET_WAIT: begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (hz.pc_load_valid) begin
          state_d = ST_RUN;
        end else begin
          pc_we = 1'b0;
          if (cnt_q == '0) begin
            err_d   = 1'b1;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      ST_INT_ENTRY: begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (cnt_q == '0) begin
          ack     = 1'b1;
          state_d = ST_RUN;
        end else begin
          pc_we = 1'b0;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = ST_RUN;
    endcase

    // Async reset must also force the control outputs immediately, not just the state.
    if (reset) begin
      pc_we   = 1'b1;
      ifid_we = 1'b1;
      flush   = 1'b0;
      bubble  = 1'b0;
      ack     = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (clr_stats)
      stall_d = '0;
    else if (!pc_we && stall_q != '1)
      stall_d = stall_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign hz.pc_write_en   = pc_we;
  assign hz.ifid_write_en = ifid_we;
  assign hz.ifid_flush    = flush;
  assign hz.idex_bubble   = bubble;
  assign hz.int_ack       = ack;

  assign hazard_err   = err_q;
  assign state_dbg    = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_response_ctrl.sv
// Scoreboard bench for hazard_response_ctrl: a reference model pushes expected outputs per
// driven cycle and the sampled DUT outputs are popped and compared mid-cycle.
module tb_hazard_response_ctrl;
  localparam int RET_TIMEOUT = 4;
  localparam int INT_LATENCY = 2;
  localparam int CNT_W       = 3;
  localparam int STAT_W      = 4;
  localparam int STAT_MAX    = (1 << STAT_W) - 1;

  localparam int LUS = 1, BR = 2, RET = 4, PLV = 8, IRQ = 16, CLR = 32;

  typedef struct packed {
    logic             pc_we;
    logic             ifid_we;
    logic             flush;
    logic             bubble;
    logic             ack;
    logic             err;
    logic [1:0]       st;
    logic [STAT_W-1:0] stall;
  } exp_t;

  typedef struct {
    string tag;
    exp_t  e;
  } sb_item_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              clr_stats;
  logic              hazard_err;
  logic [1:0]        state_dbg;
  logic [STAT_W-1:0] stall_cycles;

  hazard_response_ctrl_if hz_if ();

  hazard_response_ctrl #(
    .RET_TIMEOUT(RET_TIMEOUT),
    .INT_LATENCY(INT_LATENCY),
    .CNT_W      (CNT_W),
    .STAT_W     (STAT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hz          (hz_if.slave),
    .clr_stats   (clr_stats),
    .hazard_err  (hazard_err),
    .state_dbg   (state_dbg),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  sb_item_t exp_q[$];

  // Reference model state and its next-state values for the current cycle
  int m_state, m_cnt, m_stall;
  bit m_err;
  int n_state, n_cnt, n_stall;
  bit n_err_m;
  exp_t e_cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int v);
    hz_if.load_use_stall  = v[0];
    hz_if.branch_taken_ex = v[1];
    hz_if.ret_decode      = v[2];
    hz_if.pc_load_valid   = v[3];
    hz_if.int_req         = v[4];
    clr_stats             = v[5];
  endtask

  task automatic model_eval(input int v);
    bit pc, iw, fl, bb, ak;
    pc = 1; iw = 1; fl = 0; bb = 0; ak = 0;
    n_state = m_state; n_cnt = m_cnt; n_err_m = m_err;
    case (m_state)
      0: begin
        if (v[1]) begin
          fl = 1; bb = 1;
        end else if (v[0]) begin
          pc = 0; iw = 0; bb = 1;
        end else if (v[2]) begin
          pc = 0; fl = 1; n_state = 1; n_cnt = RET_TIMEOUT - 1;
        end else if (v[4]) begin
          pc = 0; fl = 1; bb = 1; n_state = 2; n_cnt = INT_LATENCY - 1;
        end
      end
      1: begin
        fl = 1; bb = 1;
        if (v[3]) n_state = 0;
        else begin
          pc = 0;
          if (m_cnt == 0) begin n_err_m = 1; n_state = 0; end
          else n_cnt = m_cnt - 1;
        end
      end
      default: begin
        fl = 1; bb = 1;
        if (m_cnt == 0) begin ak = 1; n_state = 0; end
        else begin pc = 0; n_cnt = m_cnt - 1; end
      end
    endcase
    if (v[5]) n_stall = 0;
    else if (!pc && m_stall < STAT_MAX) n_stall = m_stall + 1;
    else n_stall = m_stall;
    e_cur = {pc, iw, fl, bb, ak, m_err, 2'(m_state), STAT_W'(m_stall)};
  endtask

  task automatic compare_out();
    sb_item_t it;
    exp_t got;
    got = {hz_if.pc_write_en, hz_if.ifid_write_en, hz_if.ifid_flush, hz_if.idex_bubble,
           hz_if.int_ack, hazard_err, state_dbg, stall_cycles};
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      it = exp_q.pop_front();
      check(it.tag, 32'(got), 32'(it.e));
    end
  endtask

  // One clock cycle: drive, predict, sample mid-cycle, then advance model across the edge.
  task automatic step(input string tag, input int v);
    sb_item_t it;
    drive(v);
    model_eval(v);
    it.tag = tag;
    it.e   = e_cur;
    exp_q.push_back(it);
    #3;
    compare_out();
    @(posedge clk);
    m_state = n_state; m_cnt = n_cnt; m_err = n_err_m; m_stall = n_stall;
    #1;
  endtask

  task automatic apply_reset(input string tag, input int v);
    sb_item_t it;
    reset = 1'b1;
    drive(v);
    #1;
    m_state = 0; m_cnt = 0; m_err = 0; m_stall = 0;
    it.tag = tag;
    it.e   = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, STAT_W'(0)};
    exp_q.push_back(it);
    #2;
    compare_out();
    @(posedge clk);
    #1;
    exp_q.push_back(it);
    compare_out();
    reset = 1'b0;
    drive(0);
  endtask

  initial begin
    apply_reset("reset_idle", 0);
    apply_reset("reset_busy_inputs", BR | IRQ | RET | LUS);
    step("run_idle", 0);

    step("lus_stall", LUS);
    step("br_over_lus", BR | LUS);
    step("after_br", 0);

    step("ret_enter", RET);
    step("ret_wait1", 0);
    step("ret_plv", PLV);
    step("ret_done", 0);

    step("ret_to_enter", RET);
    for (int i = 0; i < RET_TIMEOUT; i++) step("ret_to_wait", BR | LUS | IRQ);
    step("ret_to_err", 0);
    step("ret_to_sticky", 0);

    step("int_defer_ret", RET);
    step("int_defer_w1", IRQ);
    step("int_defer_plv", IRQ | PLV);
    step("int_entry", IRQ);
    step("int_wait", IRQ | BR);
    step("int_ack", IRQ);
    step("int_back_run", 0);

    for (int i = 0; i < STAT_MAX + 3; i++) step("sat_stall", LUS);
    step("clr_with_stall", LUS | CLR);
    step("after_clr", 0);

    apply_reset("reset_clears_err", 0);

    step("ret_edge_enter", RET);
    for (int i = 0; i < RET_TIMEOUT - 1; i++) step("ret_edge_wait", 0);
    step("ret_edge_plv_cnt0", PLV);
    step("ret_edge_no_err", 0);

    step("abort_ret", RET);
    step("abort_ret_w", 0);
    apply_reset("abort_ret_reset", 0);
    step("abort_int", IRQ);
    step("abort_int_w", IRQ);
    apply_reset("abort_int_reset", IRQ);
    step("post_abort", 0);

    for (int i = 0; i < 300; i++) begin
      int v;
      v = int'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) v |= CLR;
      if (v[1] && $urandom_range(0, 1) == 0) v &= ~BR;
      step("rand", v);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_response_ctrl.md
Name: hazard_response_ctrl

Overview:
Pipeline control sequencer that consumes hazard and control-flow requests from decode/execute/memory and drives the write enables, flushes and bubble injection for PC, IF/ID and ID/EX. It sits beside the decode stage and owns the multi-cycle sequences for RET/RTI and interrupt entry. It also keeps a stall-cycle performance counter and a sticky RET-timeout error flag.

Parameters:
RET_TIMEOUT, 4, max cycles in RET_WAIT before giving up (>=1)
INT_LATENCY, 2, cycles spent in INT_ENTRY (>=1)
CNT_W, 3, width of internal sequence counter (must hold max(RET_TIMEOUT, INT_LATENCY))
STAT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
load_use_stall  in  1  1 = load-use/pop hazard in decode, hold one cycle
branch_taken_ex  in  1  taken branch/jump resolved in EX
ret_decode  in  1  RET/RTI in decode
pc_load_valid  in  1  memory stage has popped PC; PC mux selects popped value this cycle
int_req  in  1  level interrupt request
clr_stats  in  1  synchronous clear of stall_cycles
pc_write_en  out  1  PC register load enable
ifid_write_en  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID loads NOP at next edge
idex_bubble  out  1  ID/EX loads NOP (control bits zero) at next edge
int_ack  out  1  one-cycle pulse, PC loads interrupt vector this cycle
hazard_err  out  1  sticky: RET_WAIT timed out
state_dbg  out  2  0 RUN, 1 RET_WAIT, 2 INT_ENTRY
stall_cycles  out  STAT_W  count of cycles with pc_write_en=0, saturating

Behaviour:
- Reset (async): state RUN, seq counter 0, hazard_err 0, stall_cycles 0. Outputs while reset high: pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=0, int_ack=0. Reset mid-sequence aborts it; no int_ack emitted.
- Outputs are combinational from state, counter and inputs (same-cycle response); state, counter, stats and error update on posedge clk.
- RUN default: pc_write_en=1, ifid_write_en=1, flush=0, bubble=0.
- RUN priority (highest first):
  1. branch_taken_ex: ifid_flush=1, idex_bubble=1, pc_write_en=1, ifid_write_en=1; stay RUN. All other requests this cycle ignored (the flushed instructions re-raise them if still valid).
  2. load_use_stall: pc_write_en=0, ifid_write_en=0, idex_bubble=1; stay RUN. One bubble per asserted cycle; back-to-back assertion gives back-to-back stalls.
  3. ret_decode: pc_write_en=0, ifid_flush=1 (RET proceeds to ID/EX); next state RET_WAIT, counter<=RET_TIMEOUT-1.
  4. int_req: pc_write_en=0, ifid_flush=1, idex_bubble=1; next state INT_ENTRY, counter<=INT_LATENCY-1. If INT_LATENCY=1, int_ack and pc_write_en=1 occur in the single INT_ENTRY cycle.
- RET_WAIT: pc_write_en=0, ifid_flush=1, idex_bubble=1, ifid_write_en=1. branch_taken_ex, ret_decode, int_req and load_use_stall are ignored.
  - pc_load_valid=1: pc_write_en=1 this cycle; next state RUN.
  - Else counter==0: hazard_err<=1; next state RUN.
  - Else counter decrements.
  - pc_load_valid and counter==0 in the same cycle: treated as success, no error.
- INT_ENTRY: pc_write_en=0, ifid_flush=1, idex_bubble=1. All request inputs are ignored.
  - counter==0: int_ack=1, pc_write_en=1; next state RUN.
  - Else counter decrements.
  - int_req is not latched: it is sampled only in RUN and must stay high until int_ack.
- stall_cycles: +1 on each clock edge where pc_write_en=0 and reset is low. Holds at 2^STAT_W-1. clr_stats clears it and wins over the increment in the same cycle.
- hazard_err: cleared only by reset.
- state_dbg value 3 is never produced.

Test Plan:
- Reset high then released, all inputs 0 -> pc_write_en=1, ifid_write_en=1, flush=0, bubble=0, state_dbg=0, stall_cycles=0.
- In RUN, load_use_stall=1 for 1 cycle, then branch_taken_ex=1 together with load_use_stall=1 -> first cycle: pc_write_en=0, ifid_write_en=0, bubble=1. Second cycle: flush=1, bubble=1, pc_write_en=1. stall_cycles=1.
- ret_decode=1 for 1 cycle, pc_load_valid=1 two cycles later (RET_TIMEOUT=4) -> state_dbg 1 for 2 cycles. pc_write_en=1 on the pc_load_valid cycle, then RUN. stall_cycles=3, hazard_err=0.
- ret_decode pulse with pc_load_valid never asserted -> 4 cycles in RET_WAIT, then hazard_err=1 sticky, RUN. A later reset clears hazard_err.
- int_req held high with INT_LATENCY=2 -> entry cycle flush+bubble, 2 cycles in INT_ENTRY, int_ack high on the 2nd only. int_req arriving during RET_WAIT is deferred until RUN.
- Force stall_cycles to saturation at STAT_W=4 -> holds at 15. clr_stats asserted together with a stall cycle -> reads 0.
